// File: rtl/uart_bus_pkg.sv
// Shared state encoding and default parameters for the UART bus master.
package uart_bus_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_WRITE_ADDRESS  = 32'h1000_0000;
  localparam logic [ADDR_W-1:0] DEFAULT_READ_ADDRESS   = 32'h1000_0004;
  localparam int unsigned       DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    ACK   = 3'd3,
    GAP   = 3'd4
  } state_e;

  // A bus transaction is outstanding in these states.
  function automatic logic is_busy(input state_e s);
    return (s == WRITE) || (s == READ);
  endfunction

endpackage

// File: rtl/uart_bus_timer.sv
// Transaction watchdog: counts cycles while start is high, clear returns it to zero,
// expired flags the last allowed cycle of the wait.
module uart_bus_timer
  import uart_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int unsigned        CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Saturate on the last cycle so a late response cannot wrap the count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (start && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = start && !clear && (count_q == LAST);

endmodule

// File: rtl/uart_bus_master.sv
// UART bus master: moves bytes between a tx/rx stream interface and a memory-mapped UART.
// Define UART_BUS_MASTER_TIMEOUT_EN to abort bus transactions after TIMEOUT_CYCLES.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] WRITE_ADDRESS  = DEFAULT_WRITE_ADDRESS,
  parameter logic [ADDR_W-1:0] READ_ADDRESS   = DEFAULT_READ_ADDRESS,
  parameter int unsigned       TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [BYTE_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic [ADDR_W-1:0] rw_address,
  output logic [BYTE_W-1:0] write_data,
  output logic              write_request,
  input  logic              write_response,
  output logic              read_request,
  input  logic [ADDR_W-1:0] read_data,
  input  logic              read_response,
  input  logic              uart_irq,
  output logic              uart_irq_response,
  output logic              timeout_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rw_address_q, rw_address_d;
  logic [BYTE_W-1:0] write_data_q, write_data_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              write_request_q, write_request_d;
  logic              read_request_q, read_request_d;
  logic              irq_ack_q, irq_ack_d;
  logic              timeout_d;
  logic              tx_ready_c;
  logic              expired_c;

  // Next state and registered outputs; requests follow the state being entered.
  always_comb begin
    state_d      = state_q;
    rw_address_d = rw_address_q;
    write_data_d = write_data_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    tx_ready_c   = 1'b0;
    timeout_d    = 1'b0;

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (uart_irq && !rx_valid_q) begin
          state_d = READ;
        end else if (tx_valid_i) begin
          tx_ready_c   = 1'b1;
          write_data_d = tx_data_i;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        if (write_response) begin
          state_d = GAP;
        end else if (expired_c) begin
          timeout_d = 1'b1;
          state_d   = GAP;
        end
      end
      READ: begin
        // A completing read overrides a same-cycle drain of the holding register.
        if (read_response) begin
          rx_data_d  = read_data[BYTE_W-1:0];
          rx_valid_d = 1'b1;
          state_d    = ACK;
        end else if (expired_c) begin
          timeout_d = 1'b1;
          state_d   = GAP;
        end
      end
      ACK:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == WRITE) begin
      rw_address_d = WRITE_ADDRESS;
    end else if (state_d == READ) begin
      rw_address_d = READ_ADDRESS;
    end

    write_request_d = (state_d == WRITE);
    read_request_d  = (state_d == READ);
    irq_ack_d       = (state_d == ACK);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      rw_address_q    <= WRITE_ADDRESS;
      write_data_q    <= '0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      write_request_q <= 1'b0;
      read_request_q  <= 1'b0;
      irq_ack_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      rw_address_q    <= rw_address_d;
      write_data_q    <= write_data_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      write_request_q <= write_request_d;
      read_request_q  <= read_request_d;
      irq_ack_q       <= irq_ack_d;
    end
  end

`ifdef UART_BUS_MASTER_TIMEOUT_EN
  logic busy_c;
  logic timeout_q;

  assign busy_c = is_busy(state_q);

  uart_bus_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (busy_c),
    .clear   (!busy_c),
    .expired (expired_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_tmo_c;

  assign expired_c    = 1'b0;
  assign timeout_o    = 1'b0;
  assign unused_tmo_c = timeout_d ^ (^32'(TIMEOUT_CYCLES));
`endif

  // Only the low byte of the UART receive register carries data.
  logic unused_rd_c;
  assign unused_rd_c = ^read_data[ADDR_W-1:BYTE_W];

  assign tx_ready_o        = tx_ready_c;
  assign rx_data_o         = rx_data_q;
  assign rx_valid_o        = rx_valid_q;
  assign rw_address        = rw_address_q;
  assign write_data        = write_data_q;
  assign write_request     = write_request_q;
  assign read_request      = read_request_q;
  assign uart_irq_response = irq_ack_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: directed scenarios plus a randomized
// bus/UART environment checked against a transaction-level byte-order model.
module tb_uart_bus_master;

  localparam logic [31:0] WADDR = 32'h1000_0000;
  localparam logic [31:0] RADDR = 32'h1000_0004;
  localparam int          TMO   = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [31:0] rw_address;
  logic [7:0]  write_data;
  logic        write_request;
  logic        write_response;
  logic        read_request;
  logic [31:0] read_data;
  logic        read_response;
  logic        uart_irq;
  logic        uart_irq_response;
  logic        timeout_o;

  always #5 clock = ~clock;

  uart_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .tx_data_i         (tx_data_i),
    .tx_valid_i        (tx_valid_i),
    .tx_ready_o        (tx_ready_o),
    .rx_data_o         (rx_data_o),
    .rx_valid_o        (rx_valid_o),
    .rx_ready_i        (rx_ready_i),
    .rw_address        (rw_address),
    .write_data        (write_data),
    .write_request     (write_request),
    .write_response    (write_response),
    .read_request      (read_request),
    .read_data         (read_data),
    .read_response     (read_response),
    .uart_irq          (uart_irq),
    .uart_irq_response (uart_irq_response),
    .timeout_o         (timeout_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus slave for one write: response on the (lat+1)-th request cycle.
  task automatic serve_write(input int lat, output int hi, output logic [7:0] wd,
                             output logic [31:0] addr);
    hi = 0; wd = '0; addr = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      tx_valid_i = 1'b0;
      if (!write_request) break;
      if (hi == 0) begin
        wd   = write_data;
        addr = rw_address;
      end
      hi++;
      write_response = (hi == lat + 1);
    end
    write_response = 1'b0;
  endtask

  task automatic serve_read(input int lat, output int hi, output logic [31:0] addr);
    hi = 0; addr = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (!read_request) break;
      if (hi == 0) addr = rw_address;
      hi++;
      read_response = (hi == lat + 1);
    end
    read_response = 1'b0;
  endtask

  task automatic settle();
    tx_valid_i = 1'b0; uart_irq = 1'b0; rx_ready_i = 1'b0;
    write_response = 1'b0; read_response = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          hi;
    logic [7:0]  wd;
    logic [31:0] addr;
    logic [7:0]  wq[$];
    logic [7:0]  rq[$];
    logic        exp_ack, prev_done, last_tx_hs, quiet, wdone, rdone;
    int          wwait, rwait;

    reset_n = 1'b0; tx_data_i = '0; tx_valid_i = 1'b0; rx_ready_i = 1'b0;
    write_response = 1'b0; read_response = 1'b0; read_data = '0; uart_irq = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_tx_ready", tx_ready_o, 0);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_wreq", write_request, 0);
    check("rst_rreq", read_request, 0);
    check("rst_irq_ack", uart_irq_response, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_addr", rw_address, WADDR);
    check("rst_wdata", write_data, 0);
    reset_n = 1'b1;

    // Single write, response on the 4th request cycle
    settle();
    tx_data_i = 8'h61; tx_valid_i = 1'b1;
    #1 check("wr_ready", tx_ready_o, 1);
    serve_write(3, hi, wd, addr);
    check("wr_hi_cycles", hi, 4);
    check("wr_data", wd, 8'h61);
    check("wr_addr", addr, WADDR);
    check("wr_gap_addr_hold", rw_address, WADDR);
    tx_data_i = 8'h62; tx_valid_i = 1'b1;
    #1 check("wr_gap_ready", tx_ready_o, 0);
    @(negedge clock);
    #1 check("wr_idle_ready", tx_ready_o, 1);
    serve_write(0, hi, wd, addr);
    check("wr2_hi_cycles", hi, 1);
    check("wr2_data", wd, 8'h62);

    // Single read
    settle();
    uart_irq = 1'b1; read_data = 32'h0000_0042;
    serve_read(2, hi, addr);
    check("rd_hi_cycles", hi, 3);
    check("rd_addr", addr, RADDR);
    check("rd_ack", uart_irq_response, 1);
    check("rd_rx_valid", rx_valid_o, 1);
    check("rd_rx_data", rx_data_o, 8'h42);
    uart_irq = 1'b0;
    @(negedge clock);
    check("rd_ack_once", uart_irq_response, 0);
    check("rd_addr_hold", rw_address, RADDR);
    rx_ready_i = 1'b1;
    @(negedge clock);
    rx_ready_i = 1'b0;
    check("rd_drained", rx_valid_o, 0);

    // Read wins over a simultaneous write
    settle();
    tx_data_i = 8'h77; tx_valid_i = 1'b1; uart_irq = 1'b1; read_data = 32'hFFFF_FF55;
    #1 check("pri_ready_low", tx_ready_o, 0);
    serve_read(1, hi, addr);
    check("pri_read_first", hi, 2);
    uart_irq = 1'b0;
    #1 check("pri_ack_ready", tx_ready_o, 0);
    @(negedge clock);
    #1 check("pri_gap_ready", tx_ready_o, 0);
    @(negedge clock);
    #1 check("pri_idle_ready", tx_ready_o, 1);
    serve_write(0, hi, wd, addr);
    check("pri_wr_data", wd, 8'h77);
    rx_ready_i = 1'b1;
    check("pri_rx_data", rx_data_o, 8'h55);
    @(negedge clock);
    rx_ready_i = 1'b0;
    check("pri_drained", rx_valid_o, 0);

    // Backpressure: full holding register blocks reads, writes still flow
    settle();
    uart_irq = 1'b1; read_data = 32'h0000_0010;
    serve_read(0, hi, addr);
    read_data = 32'h0000_0011;
    tx_data_i = 8'hAB; tx_valid_i = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1 check("bp_wr_ready", tx_ready_o, 1);
    check("bp_no_read", read_request, 0);
    serve_write(1, hi, wd, addr);
    check("bp_wr_hi", hi, 2);
    check("bp_wr_data", wd, 8'hAB);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("bp_hold_rreq", read_request, 0);
      check("bp_hold_data", rx_data_o, 8'h10);
    end
    rx_ready_i = 1'b1;
    check("bp_first_byte", rx_data_o, 8'h10);
    @(negedge clock);
    rx_ready_i = 1'b0;
    check("bp_first_drained", rx_valid_o, 0);
    serve_read(0, hi, addr);
    check("bp_second_read", hi, 1);
    check("bp_second_byte", rx_data_o, 8'h11);
    uart_irq = 1'b0;
    rx_ready_i = 1'b1;
    @(negedge clock);
    rx_ready_i = 1'b0;

    // Missing response
    settle();
    tx_data_i = 8'hC3; tx_valid_i = 1'b1;
    #1 check("to_ready", tx_ready_o, 1);
`ifdef UART_BUS_MASTER_TIMEOUT_EN
    serve_write(100, hi, wd, addr);
    check("to_wr_hi", hi, TMO);
    check("to_wr_pulse", timeout_o, 1);
    @(negedge clock);
    check("to_wr_pulse_once", timeout_o, 0);
    tx_data_i = 8'h3C; tx_valid_i = 1'b1;
    #1 check("to_back_idle", tx_ready_o, 1);
    serve_write(0, hi, wd, addr);
    check("to_next_wr", wd, 8'h3C);
    @(negedge clock);
    uart_irq = 1'b1; read_data = 32'h0000_0099;
    serve_read(100, hi, addr);
    check("to_rd_hi", hi, TMO);
    check("to_rd_pulse", timeout_o, 1);
    check("to_rd_discard", rx_valid_o, 0);
    check("to_rd_no_ack", uart_irq_response, 0);
    uart_irq = 1'b0;
`else
    serve_write(40, hi, wd, addr);
    check("nt_wr_hi", hi, 41);
    check("nt_timeout_low", timeout_o, 0);
`endif

    // Reset in the middle of a read
    settle();
    uart_irq = 1'b1;
    @(negedge clock);
    check("mid_rst_in_read", read_request, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rreq", read_request, 0);
    check("mid_rst_rx_valid", rx_valid_o, 0);
    check("mid_rst_addr", rw_address, WADDR);
    uart_irq = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("mid_rst_no_retry", write_request | read_request, 0);

    // Randomized traffic against a byte-order model
    exp_ack = 1'b0; prev_done = 1'b0; last_tx_hs = 1'b0; wwait = -1; rwait = -1;
    for (int cyc = 0; cyc < 3300; cyc++) begin
      quiet = (cyc >= 3000);
      @(negedge clock);
      check("r_ack", uart_irq_response, exp_ack);
      check("r_rx_valid", rx_valid_o, rq.size() != 0);
      if (rq.size() != 0) check("r_rx_data", rx_data_o, rq[0]);
      if (prev_done) check("r_gap", write_request | read_request, 0);
      check("r_exclusive", write_request & read_request, 0);
      if (read_request) check("r_backpressure", rx_valid_o, 0);
      check("r_timeout", timeout_o, 0);

      if (!tx_valid_i || last_tx_hs) begin
        tx_valid_i = !quiet && ($urandom_range(0, 2) == 0);
        tx_data_i  = 8'($urandom);
      end
      if (quiet) uart_irq = 1'b0;
      else if ($urandom_range(0, 7) == 0) uart_irq = !uart_irq;
      rx_ready_i = quiet || ($urandom_range(0, 3) == 0);
      read_data  = $urandom;
      if (write_request) begin
        if (wwait < 0) wwait = $urandom_range(0, 4);
        write_response = (wwait == 0);
        wwait--;
      end else begin
        wwait = -1;
        write_response = ($urandom_range(0, 15) == 0);
      end
      if (read_request) begin
        if (rwait < 0) rwait = $urandom_range(0, 4);
        read_response = (rwait == 0);
        rwait--;
      end else begin
        rwait = -1;
        read_response = ($urandom_range(0, 15) == 0);
      end
      #1;

      last_tx_hs = tx_valid_i & tx_ready_o;
      if (last_tx_hs) wq.push_back(tx_data_i);
      wdone = write_request & write_response;
      rdone = read_request & read_response;
      if (wdone) begin
        check("r_waddr", rw_address, WADDR);
        check("r_wq_nonempty", wq.size() != 0, 1);
        if (wq.size() != 0) check("r_wdata", write_data, wq.pop_front());
      end
      if (rx_valid_o && rx_ready_i) begin
        check("r_rq_nonempty", rq.size() != 0, 1);
        if (rq.size() != 0) check("r_rx_order", rx_data_o, rq.pop_front());
      end
      if (rdone) begin
        check("r_raddr", rw_address, RADDR);
        rq.push_back(read_data[7:0]);
      end
      exp_ack   = rdone;
      prev_done = wdone | rdone;
    end
    check("r_tx_drained", tx_valid_i, 0);
    check("r_wq_empty", 32'(wq.size()), 0);
    check("r_rq_empty", 32'(rq.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 Parameter WRITE_ADDRESS SHALL default to 32'h1000_0000; it is the UART transmit register address.
REQ-002 Parameter READ_ADDRESS SHALL default to 32'h1000_0004; it is the UART receive register address.
REQ-003 Parameter TIMEOUT_CYCLES SHALL default to 1024; it is the maximum number of cycles to wait for a response.
REQ-004 clock  input  1  the single clock; all logic is on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 tx_data_i  input  8  byte to send to the UART.
REQ-007 tx_valid_i  input  1  tx_data_i is valid.
REQ-008 tx_ready_o  output  1  byte is accepted when tx_valid_i and tx_ready_o are both high.
REQ-009 rx_data_o  output  8  byte received from the UART.
REQ-010 rx_valid_o  output  1  rx_data_o is valid.
REQ-011 rx_ready_i  input  1  consumer takes the byte when rx_valid_o and rx_ready_i are both high.
REQ-012 rw_address  output  32  bus address.
REQ-013 write_data  output  8  bus write byte.
REQ-014 write_request  output  1  write strobe, held until write_response.
REQ-015 write_response  input  1  write completion.
REQ-016 read_request  output  1  read strobe, held until read_response.
REQ-017 read_data  input  32  read result, sampled when read_response is high.
REQ-018 read_response  input  1  read completion.
REQ-019 uart_irq  input  1  level; high means a received byte is pending.
REQ-020 uart_irq_response  output  1  one-cycle interrupt acknowledge.
REQ-021 timeout_o  output  1  one-cycle pulse when a transaction is aborted.

Function
REQ-022 The state machine SHALL have the states IDLE, WRITE, READ, ACK and GAP.
- Reset state is IDLE.
REQ-023 IDLE, read case: go to READ when uart_irq=1 and the rx holding register is empty.
- Read has priority over write when both are pending.
REQ-024 IDLE, write case: otherwise go to WRITE when tx_valid_i=1.
- tx_ready_o is high only in the IDLE cycle in which WRITE is selected.
- On that edge the byte is latched into write_data.
REQ-025 WRITE state:
- rw_address=WRITE_ADDRESS and write_request=1.
- On the cycle write_response=1, go to GAP.
REQ-026 READ state:
- rw_address=READ_ADDRESS and read_request=1.
- On the cycle read_response=1, latch read_data[7:0] into the rx holding register, set rx_valid_o, and go to ACK.
REQ-027 ACK state: uart_irq_response=1 for exactly one cycle, then go to GAP.
REQ-028 GAP state: all requests are low for one cycle, then go to IDLE.
- Each request therefore returns to 0 for at least one cycle between transactions.
REQ-029 rw_address SHALL hold its last value outside WRITE and READ.
REQ-030 The rx holding register is one entry.
- rx_valid_o clears on the rx_ready_i handshake.
- While it is full, uart_irq is not serviced (backpressure); writes continue.
REQ-031 If the handshake that drains the holding register happens in the same cycle a new read completes, the new byte SHALL win and rx_valid_o SHALL stay high.
REQ-032 A response input arriving in a state that does not expect it SHALL be ignored.

Reset
REQ-033 On reset_n=0, all outputs SHALL go asynchronously to 0, except rw_address, which goes to WRITE_ADDRESS.
- The FSM goes to IDLE, the holding register is emptied and the timer is cleared.
REQ-034 Reset in the middle of a transaction SHALL abandon it; nothing is retried after reset.

Configuration
REQ-035 With UART_BUS_MASTER_TIMEOUT_EN defined, a cycle counter SHALL run in WRITE and READ.
- After TIMEOUT_CYCLES cycles with no response, drop the request, pulse timeout_o and go to GAP.
- Any byte of an aborted transaction is discarded.
REQ-036 Without UART_BUS_MASTER_TIMEOUT_EN, the block SHALL wait for a response indefinitely, timeout_o SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-037 Package uart_bus_pkg SHALL hold the state enum, the default addresses and the default TIMEOUT_CYCLES.
REQ-038 The timeout counter SHALL be the sub-module uart_bus_timer (ports: start, clear, expired), instantiated only when the macro is defined.

Verification
REQ-039 Write: tx byte 8'h61 with write_response after 3 cycles -> write_request high for 4 cycles, write_data=8'h61, rw_address=32'h1000_0000, then a 1-cycle gap.
REQ-040 Read: uart_irq=1, read_data=32'h0000_0042 returned after 2 cycles -> rx_data_o=8'h42, rx_valid_o=1, uart_irq_response pulses once in the next cycle.
REQ-041 Priority: tx_valid_i and uart_irq rise in the same cycle -> READ first, tx_ready_o low until the write is selected after GAP.
REQ-042 Backpressure: rx_ready_i=0 with the holding register full and uart_irq=1 -> no read_request; two bytes 8'h10 and 8'h11 stream out unchanged while the write path continues.
REQ-043 Timeout (macro defined, TIMEOUT_CYCLES=16): write_response never asserted -> write_request drops after 16 cycles, timeout_o pulses once, FSM returns to IDLE.
REQ-044 Reset: reset_n=0 in mid-READ -> read_request=0 immediately, rx_valid_o=0, rw_address=32'h1000_0000.
